// File: rtl/x_mul_ctrl_pkg.sv
// Shared definitions for the multiplier issue controller, the multiplier
// stages and writeback.
package x_mul_ctrl_pkg;

  localparam int MUL_DEPTH   = 3;
  localparam int MUL_CREDITS = 4;
  localparam int MUL_TAG_W   = 5;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_cmd_t;

  typedef struct packed {
    logic [MUL_TAG_W-1:0] dest;
    mult_cmd_t            cmd;
  } mul_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/x_mul_ctrl_res_queue.sv
// Result tag FIFO: holds {dest, cmd} of retired multiplies until writeback
// consumes them. Pointers wrap modulo CREDITS; a full flag resolves wp==rp.
module mul_res_queue
  import x_mul_ctrl_pkg::*;
#(
  parameter int CREDITS = MUL_CREDITS
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  mul_tag_t i_din,
  input  logic     i_pop,
  input  logic     i_flush,
  output mul_tag_t o_dout,
  output logic     o_full,
  output logic     o_empty
);

  localparam int PW = (CREDITS > 1) ? $clog2(CREDITS) : 1;

  mul_tag_t        r_mem [CREDITS];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic            r_full;
  logic            w_empty;
  logic            w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CREDITS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_wp == r_rp) && !r_full;
  // A pop against an empty queue is dropped, even alongside a push.
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_full <= 1'b0;
    end else if (i_flush) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_push) r_wp <= ptr_inc(r_wp);
      if (w_pop)  r_rp <= ptr_inc(r_rp);
      if (i_push && !w_pop)
        r_full <= (ptr_inc(r_wp) == r_rp);
      else if (w_pop && !i_push)
        r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wp] <= i_din;
  end

  assign o_dout  = w_empty ? '0 : r_mem[r_rp];
  assign o_full  = r_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/x_mul_ctrl.sv
// Issue/sequencing controller for the three-stage multiplier: credit and
// scoreboard gated issue, per-stage valid/tag tracking, result queue, flush.
module x_mul_ctrl
  import x_mul_ctrl_pkg::*;
#(
  parameter int DEPTH   = MUL_DEPTH,
  parameter int CREDITS = MUL_CREDITS,
  parameter int TAG_W   = MUL_TAG_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                DEC2X0_EMPTY_SD,
  input  logic [1:0]          MULT_CMD_RD,
  input  logic [TAG_W-1:0]    DEST_RD,
  output logic                DEC2X0_POP_SX0,
  output logic                X0_ISSUE_SX0,
  output logic [DEPTH-1:0]    STAGE_VALID_SX,
  output logic [2**TAG_W-1:0] BUSY_REGS_SX,
  output logic                RES_VALID_SX,
  output logic [TAG_W-1:0]    RES_DEST_SX,
  output logic [1:0]          RES_CMD_SX,
  input  logic                WB_POP_SM,
  input  logic                EXCEPTION_SM,
  output logic                MUL_BUSY_SX
);

  localparam int OW = $clog2(CREDITS + 1);

  ctrl_state_t         r_state;
  logic [OW-1:0]       r_occ;
  logic [OW-1:0]       w_occ_nxt;
  logic [DEPTH-1:0]    r_vld_p;
  mul_tag_t            r_tag_p [DEPTH];
  logic [2**TAG_W-1:0] r_busy;
  logic [2**TAG_W-1:0] w_set;
  logic [2**TAG_W-1:0] w_clr;
  logic                w_issue;
  logic                w_pop;
  logic                w_q_full;
  logic                w_q_empty;
  mul_tag_t            w_head;

  // Issue uses only registered state, so a same-cycle pop of the head's
  // destination still blocks it for this cycle.
  assign w_issue = !DEC2X0_EMPTY_SD && (r_state != ST_FLUSH) && !EXCEPTION_SM &&
                   (r_occ < OW'(CREDITS)) &&
                   !((DEST_RD != '0) && r_busy[DEST_RD]);
  assign w_pop     = WB_POP_SM && !w_q_empty && !EXCEPTION_SM;
  assign w_occ_nxt = r_occ + OW'(w_issue) - OW'(w_pop);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_issue && (DEST_RD != '0)) w_set[DEST_RD] = 1'b1;
    if (w_pop) w_clr[w_head.dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else if (EXCEPTION_SM) begin
      r_state <= ST_FLUSH;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_issue) r_state <= ST_RUN;
        ST_RUN:   if ((w_occ_nxt == '0) && !w_issue) r_state <= ST_IDLE;
        ST_FLUSH: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // X0 -> X1 -> X2 valid shift; bubbles ride along as zero valids.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p <= '0;
      r_occ   <= '0;
      r_busy  <= '0;
    end else if (EXCEPTION_SM) begin
      r_vld_p <= '0;
      r_occ   <= '0;
      r_busy  <= '0;
    end else begin
      r_vld_p <= {r_vld_p[DEPTH-2:0], w_issue};
      r_occ   <= w_occ_nxt;
      r_busy  <= (r_busy & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk) begin
    r_tag_p[0] <= '{dest: DEST_RD, cmd: mult_cmd_t'(MULT_CMD_RD)};
    for (int k = 1; k < DEPTH; k++) r_tag_p[k] <= r_tag_p[k-1];
  end

  // X2 retire into the result queue.
  mul_res_queue #(
    .CREDITS (CREDITS)
  ) u_res_queue (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (r_vld_p[DEPTH-1]),
    .i_din   (r_tag_p[DEPTH-1]),
    .i_pop   (w_pop),
    .i_flush (EXCEPTION_SM),
    .o_dout  (w_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  a_occ_bound: assert property (@(posedge clk) disable iff (!reset_n)
    r_occ <= OW'(CREDITS));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(r_vld_p[DEPTH-1] && w_q_full));

  assign DEC2X0_POP_SX0 = w_issue;
  assign X0_ISSUE_SX0   = w_issue;
  assign STAGE_VALID_SX = r_vld_p;
  assign BUSY_REGS_SX   = r_busy;
  assign RES_VALID_SX   = !w_q_empty;
  assign RES_DEST_SX    = w_head.dest;
  assign RES_CMD_SX     = w_head.cmd;
  assign MUL_BUSY_SX    = (r_occ != '0);

endmodule

// File: tb/tb_x_mul_ctrl.sv
// Directed bench for x_mul_ctrl with a small pending-op model for drains and
// a randomised issue/pop/flush stretch.
module tb_x_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        DEC2X0_EMPTY_SD = 1'b1;
  logic [1:0]  MULT_CMD_RD = 2'd0;
  logic [4:0]  DEST_RD = 5'd0;
  logic        DEC2X0_POP_SX0;
  logic        X0_ISSUE_SX0;
  logic [2:0]  STAGE_VALID_SX;
  logic [31:0] BUSY_REGS_SX;
  logic        RES_VALID_SX;
  logic [4:0]  RES_DEST_SX;
  logic [1:0]  RES_CMD_SX;
  logic        WB_POP_SM = 1'b0;
  logic        EXCEPTION_SM = 1'b0;
  logic        MUL_BUSY_SX;

  x_mul_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .DEC2X0_EMPTY_SD (DEC2X0_EMPTY_SD),
    .MULT_CMD_RD     (MULT_CMD_RD),
    .DEST_RD         (DEST_RD),
    .DEC2X0_POP_SX0  (DEC2X0_POP_SX0),
    .X0_ISSUE_SX0    (X0_ISSUE_SX0),
    .STAGE_VALID_SX  (STAGE_VALID_SX),
    .BUSY_REGS_SX    (BUSY_REGS_SX),
    .RES_VALID_SX    (RES_VALID_SX),
    .RES_DEST_SX     (RES_DEST_SX),
    .RES_CMD_SX      (RES_CMD_SX),
    .WB_POP_SM       (WB_POP_SM),
    .EXCEPTION_SM    (EXCEPTION_SM),
    .MUL_BUSY_SX     (MUL_BUSY_SX)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_bad = 0;
  logic [6:0] op_q[$];
  logic [6:0] exp_q[$];
  bit         prev_exc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] tg(input int dest, input int cmd);
    return {5'(dest), 2'(cmd)};
  endfunction

  function automatic logic [31:0] pend_mask();
    logic [31:0] m = '0;
    foreach (exp_q[i]) if (exp_q[i][6:2] != 5'd0) m[exp_q[i][6:2]] = 1'b1;
    return m;
  endfunction

  // One directed cycle: drive inputs, then check the combinational issue.
  task automatic cyc(input string tag, input bit emp, input int dest, input int cmd,
                     input bit wb, input bit exc, input bit exp_pop);
    @(posedge clk); #1;
    DEC2X0_EMPTY_SD = emp;
    DEST_RD         = 5'(dest);
    MULT_CMD_RD     = 2'(cmd);
    WB_POP_SM       = wb;
    EXCEPTION_SM    = exc;
    prev_exc        = exc;
    #1;
    chk({tag, ".pop"}, 32'(DEC2X0_POP_SX0), 32'(exp_pop));
    chk({tag, ".iss"}, 32'(X0_ISSUE_SX0), 32'(exp_pop));
  endtask

  // Model-checked run: ops from op_q (or random), expected pops from exp_q.
  task automatic run(input int ncyc, input bit rnd);
    logic [6:0]  head = '0;
    bit          have = 1'b0;
    bit          emp, wb, exc, exp_iss, do_pop;
    logic [31:0] m;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (prev_exc) exp_q.delete();
      m = pend_mask();
      chk("busy_regs", BUSY_REGS_SX, m);
      chk("mul_busy", 32'(MUL_BUSY_SX), 32'(exp_q.size() != 0));
      if (rnd) begin
        if (!have) begin
          head = {5'($urandom_range(7)), 2'($urandom_range(3))};
          have = 1'b1;
        end
        emp = ($urandom_range(4) == 0);
        wb  = 1'($urandom_range(1));
        exc = ($urandom_range(99) == 0);
      end else begin
        emp = (op_q.size() == 0);
        if (!emp) head = op_q[0];
        wb  = 1'b1;
        exc = 1'b0;
      end
      DEC2X0_EMPTY_SD = emp;
      DEST_RD         = head[6:2];
      MULT_CMD_RD     = head[1:0];
      WB_POP_SM       = wb;
      EXCEPTION_SM    = exc;
      exp_iss = !emp && !prev_exc && !exc && (exp_q.size() < 4) &&
                !((head[6:2] != 5'd0) && m[head[6:2]]);
      prev_exc = exc;
      #1;
      chk("issue", 32'(DEC2X0_POP_SX0), 32'(exp_iss));
      do_pop = wb && RES_VALID_SX && !exc;
      if (do_pop) begin
        if (exp_q.size() == 0) chk("res_unexpected", 32'(RES_VALID_SX), 32'd0);
        else chk("res_order", 32'({RES_DEST_SX, RES_CMD_SX}), 32'(exp_q.pop_front()));
      end
      if (DEC2X0_POP_SX0) begin
        exp_q.push_back(head);
        if (rnd) have = 1'b0;
        else void'(op_q.pop_front());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("rst.stage", 32'(STAGE_VALID_SX), 32'd0);
    chk("rst.busy", BUSY_REGS_SX, 32'd0);
    chk("rst.rv", 32'(RES_VALID_SX), 32'd0);
    chk("rst.rd", 32'(RES_DEST_SX), 32'd0);
    chk("rst.rc", 32'(RES_CMD_SX), 32'd0);
    chk("rst.mb", 32'(MUL_BUSY_SX), 32'd0);
    @(posedge clk); @(posedge clk); #3 reset_n = 1'b1;

    // single MUL to x5
    cyc("t1c0", 0, 5, 0, 0, 0, 1); chk("t1c0.mb", 32'(MUL_BUSY_SX), 32'd0);
    cyc("t1c1", 1, 0, 0, 0, 0, 0); chk("t1c1.stage", 32'(STAGE_VALID_SX), 32'd1);
    chk("t1c1.busy", BUSY_REGS_SX, 32'h20); chk("t1c1.mb", 32'(MUL_BUSY_SX), 32'd1);
    cyc("t1c2", 1, 0, 0, 0, 0, 0); chk("t1c2.stage", 32'(STAGE_VALID_SX), 32'd2);
    cyc("t1c3", 1, 0, 0, 0, 0, 0); chk("t1c3.stage", 32'(STAGE_VALID_SX), 32'd4);
    chk("t1c3.rv", 32'(RES_VALID_SX), 32'd0);
    cyc("t1c4", 1, 0, 0, 1, 0, 0); chk("t1c4.rv", 32'(RES_VALID_SX), 32'd1);
    chk("t1c4.rd", 32'(RES_DEST_SX), 32'd5); chk("t1c4.rc", 32'(RES_CMD_SX), 32'd0);
    chk("t1c4.stage", 32'(STAGE_VALID_SX), 32'd0); chk("t1c4.busy", BUSY_REGS_SX, 32'h20);
    cyc("t1c5", 1, 0, 0, 0, 0, 0); chk("t1c5.rv", 32'(RES_VALID_SX), 32'd0);
    chk("t1c5.busy", BUSY_REGS_SX, 32'd0); chk("t1c5.mb", 32'(MUL_BUSY_SX), 32'd0);

    // credits: x1..x4 issue, x5 stalls until one pop
    cyc("t2c0", 0, 1, 0, 0, 0, 1);
    cyc("t2c1", 0, 2, 0, 0, 0, 1);
    cyc("t2c2", 0, 3, 0, 0, 0, 1);
    cyc("t2c3", 0, 4, 0, 0, 0, 1);
    cyc("t2c4", 0, 5, 0, 0, 0, 0); chk("t2c4.rd", 32'(RES_DEST_SX), 32'd1);
    cyc("t2c5", 0, 5, 0, 0, 0, 0);
    cyc("t2c6", 0, 5, 0, 0, 0, 0); chk("t2c6.rv", 32'(RES_VALID_SX), 32'd1);
    cyc("t2c7", 0, 5, 0, 1, 0, 0); chk("t2c7.rd", 32'(RES_DEST_SX), 32'd1);
    cyc("t2c8", 0, 5, 0, 0, 0, 1); chk("t2c8.rd", 32'(RES_DEST_SX), 32'd2);
    cyc("t2c9", 0, 6, 0, 1, 0, 0);
    cyc("t2c10", 0, 6, 0, 1, 0, 1); chk("t2c10.rd", 32'(RES_DEST_SX), 32'd3);
    cyc("t2c11", 0, 7, 0, 0, 0, 1); chk("t2c11.rd", 32'(RES_DEST_SX), 32'd4);
    cyc("t2c12", 0, 8, 0, 0, 0, 0); chk("t2c12.rd", 32'(RES_DEST_SX), 32'd4);
    exp_q = '{tg(4, 0), tg(5, 0), tg(6, 0), tg(7, 0)};
    run(20, 0); chk("t2.left", 32'(exp_q.size()), 32'd0);

    // WAW on x7, then x0 ops
    cyc("t3c0", 0, 7, 1, 0, 0, 1);
    cyc("t3c1", 0, 7, 3, 0, 0, 0);
    cyc("t3c2", 0, 7, 3, 0, 0, 0);
    cyc("t3c3", 0, 7, 3, 0, 0, 0);
    cyc("t3c4", 0, 7, 3, 1, 0, 0); chk("t3c4.rd", 32'(RES_DEST_SX), 32'd7);
    chk("t3c4.rc", 32'(RES_CMD_SX), 32'd1);
    cyc("t3c5", 0, 7, 3, 0, 0, 1); chk("t3c5.busy", BUSY_REGS_SX, 32'd0);
    cyc("t3c6", 0, 0, 2, 0, 0, 1); chk("t3c6.busy", BUSY_REGS_SX, 32'h80);
    cyc("t3c7", 0, 0, 2, 0, 0, 1);
    cyc("t3c8", 0, 0, 2, 0, 0, 1);
    cyc("t3c9", 0, 0, 2, 0, 0, 0); chk("t3c9.busy", BUSY_REGS_SX, 32'h80);
    exp_q = '{tg(7, 3), tg(0, 2), tg(0, 2), tg(0, 2)};
    run(20, 0); chk("t3.left", 32'(exp_q.size()), 32'd0);

    // flush with two queued and two in flight
    cyc("t4c0", 0, 1, 0, 0, 0, 1);
    cyc("t4c1", 0, 2, 0, 0, 0, 1);
    cyc("t4c2", 0, 3, 0, 0, 0, 1);
    cyc("t4c3", 0, 4, 0, 0, 0, 1);
    cyc("t4c4", 0, 9, 0, 0, 0, 0);
    cyc("t4c5", 0, 9, 0, 1, 1, 0); chk("t4c5.rv", 32'(RES_VALID_SX), 32'd1);
    cyc("t4c6", 0, 9, 0, 0, 0, 0); chk("t4c6.stage", 32'(STAGE_VALID_SX), 32'd0);
    chk("t4c6.busy", BUSY_REGS_SX, 32'd0); chk("t4c6.mb", 32'(MUL_BUSY_SX), 32'd0);
    chk("t4c6.rv", 32'(RES_VALID_SX), 32'd0);
    cyc("t4c7", 0, 9, 0, 0, 0, 1);
    exp_q = '{tg(9, 0)};
    run(12, 0); chk("t4.left", 32'(exp_q.size()), 32'd0);
    cyc("t4e0", 0, 10, 0, 0, 1, 0);
    cyc("t4e1", 0, 10, 0, 0, 1, 0);
    cyc("t4e2", 0, 10, 0, 0, 0, 0);
    cyc("t4e3", 0, 10, 0, 0, 0, 1);
    exp_q = '{tg(10, 0)};
    run(12, 0); chk("t4e.left", 32'(exp_q.size()), 32'd0);

    // async reset with three queued, then ten ops across pointer wrap
    cyc("t5c0", 0, 1, 0, 0, 0, 1);
    cyc("t5c1", 0, 2, 1, 0, 0, 1);
    cyc("t5c2", 0, 3, 2, 0, 0, 1);
    cyc("t5c3", 1, 0, 0, 0, 0, 0);
    cyc("t5c4", 1, 0, 0, 0, 0, 0);
    cyc("t5c5", 1, 0, 0, 0, 0, 0);
    cyc("t5c6", 1, 0, 0, 0, 0, 0); chk("t5c6.rv", 32'(RES_VALID_SX), 32'd1);
    chk("t5c6.rd", 32'(RES_DEST_SX), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5r.rv", 32'(RES_VALID_SX), 32'd0);
    chk("t5r.busy", BUSY_REGS_SX, 32'd0);
    chk("t5r.mb", 32'(MUL_BUSY_SX), 32'd0);
    chk("t5r.rd", 32'(RES_DEST_SX), 32'd0);
    @(posedge clk); @(posedge clk); #3 reset_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 10; i++) op_q.push_back(tg(i + 1, i % 4));
    run(60, 0);
    chk("t5.left", 32'(exp_q.size()), 32'd0);
    chk("t5.ops", 32'(op_q.size()), 32'd0);

    // random issue/pop/flush against the pending-op model
    run(2000, 1);
    run(40, 0);
    chk("rnd.left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
